writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_W, default 16, datapath width of results, registers and AC.
REQ-002 Parameter NUM_REGS, default 4, number of architectural registers; register 0 is the accumulator AC.
REQ-003 Parameter REG_AW, default 2, register-address width; SHALL be >= clog2(NUM_REGS).
REQ-004 Parameter CNT_W, default 16, retire-counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 halt_program  input  1  freeze; no accept, no commit, no count.
REQ-008 in_valid  input  1  execute stage presents a result.
REQ-009 in_ready  output  1  writeback can accept this cycle.
REQ-010 in_dest  input  REG_AW  destination register.
REQ-011 in_we  input  1  1 = write register; 0 = retire without write (store/branch).
REQ-012 in_sel  input  1  0 = take alu_result, 1 = take data_out.
REQ-013 alu_result  input  DATA_W  ALU result.
REQ-014 data_out  input  DATA_W  memory read data.
REQ-015 rd_addr_a, rd_addr_b  input  REG_AW  read-port addresses.
REQ-016 rd_data_a, rd_data_b  output  DATA_W  read-port data.
REQ-017 AC  output  DATA_W  committed contents of register 0.
REQ-018 fwd_valid, fwd_dest, fwd_data  output  1/REG_AW/DATA_W  pending-write bypass info.
REQ-019 retire_count  output  CNT_W  number of committed instructions.

Function
REQ-020 Two-step operation: stage register S {valid, we, dest, data} captures on accept; S commits to the register file on the next unhalted edge.
REQ-021 in_ready SHALL equal !halt_program (combinational); accept = in_valid && in_ready.
REQ-022 On accept, S.data SHALL be in_sel ? data_out : alu_result, sampled at that edge.
REQ-023 Commit (S.valid && !halt_program): if S.we and S.dest < NUM_REGS, write S.data to regs[S.dest]; retire_count increments by 1 regardless of S.we.
REQ-024 retire_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 S.dest >= NUM_REGS with S.we=1: write dropped, instruction still retired.
REQ-026 Simultaneous commit and accept: old S commits, new S loaded the same edge; back-to-back throughput one result per cycle.
REQ-027 Commit without accept: S.valid cleared.
REQ-028 halt_program=1: S, registers, AC and retire_count hold; read ports and bypass stay live.
REQ-029 Latency: result accepted at edge N appears in regs/AC after edge N+1 (if unhalted); visible on rd_data via bypass from after edge N.
REQ-030 Read ports combinational: rd_data_x = S.data when S.valid && S.we && S.dest == rd_addr_x, else regs[rd_addr_x]; rd_addr_x >= NUM_REGS reads 0.
REQ-031 AC SHALL reflect regs[0] only (committed value, never bypassed).
REQ-032 fwd_valid = S.valid && S.we; fwd_dest = S.dest; fwd_data = S.data.

Reset
REQ-033 rst=1 at an edge: all registers, AC, retire_count = 0; S.valid = 0; overrides halt_program and in_valid.
REQ-034 Reset while S is valid SHALL discard the pending write, with no commit and no count.
REQ-035 While rst=1, in_ready follows REQ-021; inputs accepted that cycle are discarded.

Verification
REQ-036 Reset, then accept {dest 0, we 1, sel 0, alu_result 16'h1234} -> fwd_valid=1 next cycle; AC=16'h1234 and retire_count=1 one edge later.
REQ-037 Back-to-back: dest 1 <- 16'h00AA (sel 1 via data_out), then dest 1 <- 16'h00BB -> rd_data_a(addr 1) shows 16'h00AA then 16'h00BB on consecutive cycles; final regs[1]=16'h00BB, count=2.
REQ-038 Accept dest 2 = 16'h5555, assert halt for 3 cycles -> in_ready=0, regs[2] still 0, rd_data(addr 2)=16'h5555 via bypass, count frozen; release -> commits, count+1.
REQ-039 Accept with we=0, dest 0, alu_result 16'hFFFF -> AC unchanged, fwd_valid=0, retire_count +1.
REQ-040 Preload retire_count to 16'hFFFF via 65535 retires (or force), one more retire -> retire_count=0.
REQ-041 Accept dest 3 = 16'h0F0F, assert rst on the next edge -> regs[3]=0, retire_count=0, fwd_valid=0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: a one-entry staging register that commits results into a small
// register file one edge after acceptance, with combinational bypass and a retire counter.
module writeback_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_program,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_we,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] data_out,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] AC,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              s_valid_q, s_valid_d;
    logic              s_we_q, s_we_d;
    logic [REG_AW-1:0] s_dest_q, s_dest_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              accept;
    logic              commit;

    assign in_ready = !halt_program;
    assign accept   = in_valid && in_ready;
    assign commit   = s_valid_q && !halt_program;

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        s_valid_d = s_valid_q;
        s_we_d    = s_we_q;
        s_dest_d  = s_dest_q;
        s_data_d  = s_data_q;
        cnt_d     = cnt_q;
        if (!halt_program) begin
            s_valid_d = accept;
            if (accept) begin
                s_we_d   = in_we;
                s_dest_d = in_dest;
                s_data_d = in_sel ? data_out : alu_result;
            end
        end
        if (commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the register file is architectural state that must read 0 after reset, so it is reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_we_q    <= 1'b0;
            s_dest_q  <= '0;
            s_data_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            s_valid_q <= s_valid_d;
            s_we_q    <= s_we_d;
            s_dest_q  <= s_dest_d;
            s_data_q  <= s_data_d;
            cnt_q     <= cnt_d;
            // A destination with no matching entry simply writes nothing but still retires.
            if (commit && s_we_q) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (s_dest_q == REG_AW'(i)) begin
                        regs_q[i] <= s_data_q;
                    end
                end
            end
        end
    end

    assign fwd_valid    = s_valid_q && s_we_q;
    assign fwd_dest     = s_dest_q;
    assign fwd_data     = s_data_q;
    assign AC           = regs_q[0];
    assign retire_count = cnt_q;

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == REG_AW'(i)) rd_data_a = regs_q[i];
            if (rd_addr_b == REG_AW'(i)) rd_data_b = regs_q[i];
        end
        if (fwd_valid && s_dest_q == rd_addr_a) rd_data_a = s_data_q;
        if (fwd_valid && s_dest_q == rd_addr_b) rd_data_b = s_data_q;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: accepted results are queued as expected
// commits and checked against the register file and retire counter when they commit.
module tb_writeback_unit;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;
    localparam int CNT_W    = 16;

    typedef struct {
        logic              we;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              halt_program;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_dest;
    logic              in_we;
    logic              in_sel;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] data_out;
    logic [REG_AW-1:0] rd_addr_a;
    logic [REG_AW-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] AC;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_dest;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  retire_count;

    int                vectors     = 0;
    int                miscompares = 0;
    exp_t              sb[$];
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [CNT_W-1:0]  m_cnt;

    writeback_unit #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .halt_program(halt_program),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
        .in_we(in_we), .in_sel(in_sel), .alu_result(alu_result), .data_out(data_out),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .AC(AC),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    endtask

    // Drive one result for the next edge and queue its expected commit.
    task automatic accept(input logic we, input logic [REG_AW-1:0] dest, input logic sel,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        exp_t e;
        in_valid   = 1'b1;
        in_we      = we;
        in_dest    = dest;
        in_sel     = sel;
        alu_result = alu;
        data_out   = mem;
        e.we   = we;
        e.dest = dest;
        e.data = sel ? mem : alu;
        sb.push_back(e);
        step();
    endtask

    // Called just after the edge on which the oldest queued result should have committed.
    task automatic retire_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: scoreboard empty at commit", name);
            return;
        end
        e = sb.pop_front();
        if (e.we && int'(e.dest) < NUM_REGS) m_regs[e.dest] = e.data;
        m_cnt = m_cnt + 1'b1;
        vectors++;
        if (retire_count !== m_cnt) begin
            miscompares++;
            $display("FAIL %s count: got %h expected %h", name, retire_count, m_cnt);
        end
        vectors++;
        if (AC !== m_regs[0]) begin
            miscompares++;
            $display("FAIL %s AC: got %h expected %h", name, AC, m_regs[0]);
        end
        if (sb.size() == 0) begin
            rd_addr_b = e.dest;
            #1;
            vectors++;
            if (rd_data_b !== m_regs[e.dest]) begin
                miscompares++;
                $display("FAIL %s reg[%0d]: got %h expected %h", name, e.dest, rd_data_b, m_regs[e.dest]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; halt_program = 1'b0; idle();
        in_we = 1'b0; in_dest = '0; in_sel = 1'b0; alu_result = '0; data_out = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        step(); step();
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL reset fwd_valid: got %b expected 0", fwd_valid); end
        vectors++;
        if (retire_count !== '0) begin miscompares++; $display("FAIL reset count: got %h expected 0", retire_count); end
        vectors++;
        if (AC !== '0) begin miscompares++; $display("FAIL reset AC: got %h expected 0", AC); end
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr_a = REG_AW'(i);
            #1;
            vectors++;
            if (rd_data_a !== '0) begin miscompares++; $display("FAIL reset reg[%0d]: got %h expected 0", i, rd_data_a); end
        end
    endtask

    task automatic test_basic();
        accept(1'b1, 2'd0, 1'b0, 16'h1234, 16'hDEAD);
        idle();
        rd_addr_a = 2'd0;
        #1;
        vectors++;
        if (fwd_valid !== 1'b1 || fwd_dest !== 2'd0 || fwd_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL basic fwd: got %b/%h/%h expected 1/0/1234", fwd_valid, fwd_dest, fwd_data);
        end
        vectors++;
        if (AC !== 16'h0000) begin miscompares++; $display("FAIL basic AC early: got %h expected 0000", AC); end
        vectors++;
        if (rd_data_a !== 16'h1234) begin miscompares++; $display("FAIL basic bypass: got %h expected 1234", rd_data_a); end
        step();
        retire_check("basic");
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL basic fwd clear: got %b expected 0", fwd_valid); end
    endtask

    task automatic test_back_to_back();
        rd_addr_a = 2'd1;
        accept(1'b1, 2'd1, 1'b1, 16'h0077, 16'h00AA);
        #1;
        vectors++;
        if (rd_data_a !== 16'h00AA) begin miscompares++; $display("FAIL b2b first: got %h expected 00AA", rd_data_a); end
        accept(1'b1, 2'd1, 1'b0, 16'h00BB, 16'h0011);
        idle();
        retire_check("b2b first commit");
        rd_addr_a = 2'd1;
        #1;
        vectors++;
        if (rd_data_a !== 16'h00BB) begin miscompares++; $display("FAIL b2b second: got %h expected 00BB", rd_data_a); end
        step();
        retire_check("b2b second commit");
    endtask

    task automatic test_halt();
        accept(1'b1, 2'd2, 1'b0, 16'h5555, 16'h0000);
        // Offered during halt; must never be accepted, so it is not queued.
        in_valid = 1'b1; in_we = 1'b1; in_dest = 2'd3; in_sel = 1'b0; alu_result = 16'hABCD;
        halt_program = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL halt in_ready: got %b expected 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            rd_addr_b = 2'd2;
            #1;
            vectors++;
            if (rd_data_b !== 16'h5555) begin miscompares++; $display("FAIL halt bypass c%0d: got %h expected 5555", c, rd_data_b); end
            vectors++;
            if (retire_count !== m_cnt) begin miscompares++; $display("FAIL halt count c%0d: got %h expected %h", c, retire_count, m_cnt); end
            vectors++;
            if (fwd_valid !== 1'b1 || fwd_dest !== 2'd2) begin
                miscompares++; $display("FAIL halt fwd c%0d: got %b/%h expected 1/2", c, fwd_valid, fwd_dest);
            end
        end
        halt_program = 1'b0;
        idle();
        step();
        retire_check("halt release");
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL halt leak: got fwd_valid %b expected 0", fwd_valid); end
    endtask

    task automatic test_no_write();
        accept(1'b0, 2'd0, 1'b0, 16'hFFFF, 16'h0000);
        idle();
        rd_addr_a = 2'd0;
        #1;
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL nowrite fwd_valid: got %b expected 0", fwd_valid); end
        vectors++;
        if (rd_data_a !== m_regs[0]) begin miscompares++; $display("FAIL nowrite read: got %h expected %h", rd_data_a, m_regs[0]); end
        step();
        retire_check("nowrite");
    endtask

    task automatic test_wrap();
        int n;
        n = 16'hFFFF - int'(m_cnt);
        in_valid = 1'b1; in_we = 1'b0; in_dest = 2'd0; in_sel = 1'b0; alu_result = 16'h9999;
        repeat (n) step();
        idle();
        step();
        m_cnt = m_cnt + CNT_W'(n);
        vectors++;
        if (retire_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap pre: got %h expected FFFF", retire_count); end
        vectors++;
        if (AC !== m_regs[0]) begin miscompares++; $display("FAIL wrap AC: got %h expected %h", AC, m_regs[0]); end
        accept(1'b0, 2'd1, 1'b0, 16'h4242, 16'h0000);
        idle();
        step();
        retire_check("wrap");
        vectors++;
        if (retire_count !== 16'h0000) begin miscompares++; $display("FAIL wrap zero: got %h expected 0000", retire_count); end
    endtask

    task automatic test_reset_pending();
        accept(1'b1, 2'd3, 1'b0, 16'h0F0F, 16'h0000);
        rst = 1'b1;
        in_valid = 1'b1; in_we = 1'b1; in_dest = 2'd2; in_sel = 1'b0; alu_result = 16'h1111;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstpend in_ready: got %b expected 1", in_ready); end
        step();
        rst = 1'b0;
        idle();
        model_reset();
        rd_addr_a = 2'd2; rd_addr_b = 2'd3;
        #1;
        vectors++;
        if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL rstpend fwd_valid: got %b expected 0", fwd_valid); end
        vectors++;
        if (retire_count !== '0) begin miscompares++; $display("FAIL rstpend count: got %h expected 0", retire_count); end
        vectors++;
        if (rd_data_b !== '0) begin miscompares++; $display("FAIL rstpend reg[3]: got %h expected 0", rd_data_b); end
        vectors++;
        if (rd_data_a !== '0) begin miscompares++; $display("FAIL rstpend reg[2]: got %h expected 0", rd_data_a); end
        vectors++;
        if (AC !== '0) begin miscompares++; $display("FAIL rstpend AC: got %h expected 0", AC); end
        step();
        #1;
        vectors++;
        if (retire_count !== '0 || rd_data_b !== '0) begin
            miscompares++; $display("FAIL rstpend late commit: got count %h reg[3] %h expected 0/0", retire_count, rd_data_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_halt();
        test_no_write();
        test_wrap();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
